// File: rtl/axil_regfile_slave.sv
// axil_regfile_slave: AXI4-Lite register file slave, registers exported flat.
// Define AXIL_WSTRB_EN to honour WSTRB byte lanes on writes.
module axil_regfile_slave #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int NUM_REGS = 8,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic [ADDR_W-1:0]          AWADDR,
  input  logic                       AWVALID,
  output logic                       AWREADY,
  input  logic [DATA_W-1:0]          WDATA,
  input  logic [DATA_W/8-1:0]        WSTRB,
  input  logic                       WVALID,
  output logic                       WREADY,
  output logic [1:0]                 BRESP,
  output logic                       BVALID,
  input  logic                       BREADY,
  input  logic [ADDR_W-1:0]          ARADDR,
  input  logic                       ARVALID,
  output logic                       ARREADY,
  output logic [DATA_W-1:0]          RDATA,
  output logic [1:0]                 RRESP,
  output logic                       RVALID,
  input  logic                       RREADY,
  output logic [NUM_REGS*DATA_W-1:0] reg_out
);
  localparam int STRB_W = DATA_W / 8;
  localparam int LSB = $clog2(STRB_W);
  localparam int IDX_W = ADDR_W - LSB;

  logic              aw_full, w_full;
  logic              aw_full_n, w_full_n, rvalid_n;
  logic [IDX_W-1:0]  aw_idx, ar_idx;
  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] wmask, rd_word;
  logic              aw_hs, w_hs, ar_hs;
  logic              commit, aw_ok, ar_ok;
  logic              unused_bits;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs = WVALID && WREADY;
  assign ar_hs = ARVALID && ARREADY;
  assign commit = aw_full && w_full && (!BVALID || BREADY);
  assign ar_idx = ARADDR[ADDR_W-1:LSB];
  assign aw_ok = 32'(aw_idx) < 32'(NUM_REGS);
  assign ar_ok = 32'(ar_idx) < 32'(NUM_REGS);
  assign aw_full_n = (aw_full && !commit) || aw_hs;
  assign w_full_n = (w_full && !commit) || w_hs;
  assign rvalid_n = ar_hs || (RVALID && !RREADY);
  assign unused_bits = ^{AWADDR[LSB-1:0], ARADDR[LSB-1:0], w_strb};

`ifdef AXIL_WSTRB_EN
  // Expand byte strobes into a bit mask
  always_comb begin
    wmask = '0;
    for (int k = 0; k < STRB_W; k++)
      wmask[8*k +: 8] = {8{w_strb[k]}};
  end
`else
  assign wmask = '1;
`endif

  // Read mux; out-of-range indices fall through to zero
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (32'(ar_idx) == 32'(i)) rd_word = regs[i];
  end

  // Flat export of the register array
  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++)
      reg_out[i*DATA_W +: DATA_W] = regs[i];
  end

  // AW and W holding buffers; ready mirrors buffer emptiness
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_full <= 1'b0;
      w_full <= 1'b0;
      aw_idx <= '0;
      w_data <= '0;
      w_strb <= '0;
      AWREADY <= 1'b0;
      WREADY <= 1'b0;
    end else begin
      aw_full <= aw_full_n;
      w_full <= w_full_n;
      AWREADY <= !aw_full_n;
      WREADY <= !w_full_n;
      if (aw_hs) aw_idx <= AWADDR[ADDR_W-1:LSB];
      if (w_hs) begin
        w_data <= WDATA;
        w_strb <= WSTRB;
      end
    end
  end

  // Register array, updated on an in-range commit
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL;
    end else if (commit && aw_ok) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (32'(aw_idx) == 32'(i))
          regs[i] <= (regs[i] & ~wmask) | (w_data & wmask);
    end
  end

  // Write response; a commit on the handshake edge re-arms BVALID
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      BVALID <= 1'b0;
      BRESP <= 2'b00;
    end else if (commit) begin
      BVALID <= 1'b1;
      BRESP <= aw_ok ? 2'b00 : 2'b10;
    end else if (BVALID && BREADY) begin
      BVALID <= 1'b0;
    end
  end

  // Read channel; data captured at AR accept, so it is the pre-commit value
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      RVALID <= 1'b0;
      RDATA <= '0;
      RRESP <= 2'b00;
      ARREADY <= 1'b0;
    end else begin
      ARREADY <= !rvalid_n;
      if (ar_hs) begin
        RVALID <= 1'b1;
        RDATA <= ar_ok ? rd_word : '0;
        RRESP <= ar_ok ? 2'b00 : 2'b10;
      end else if (RVALID && RREADY) begin
        RVALID <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axil_regfile_slave.sv
// tb_axil_regfile_slave: randomized bench with a transaction-level model.
// Honours AXIL_WSTRB_EN when it is defined for the build.
module tb_axil_regfile_slave;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 12;
  localparam int NUM_REGS = 8;
  localparam logic [31:0] RST_VAL = 32'hA5A5_0F0F;

  logic ACLK, ARESETN;
  logic [ADDR_W-1:0] AWADDR, ARADDR;
  logic AWVALID, AWREADY, WVALID, WREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0] WSTRB;
  logic [1:0] BRESP, RRESP;
  logic BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
  logic [NUM_REGS*DATA_W-1:0] reg_out;

  logic [31:0] model [NUM_REGS];
  int errors = 0;
  int checks = 0;

  axil_regfile_slave #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .NUM_REGS(NUM_REGS), .RST_VAL(RST_VAL)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg_out(reg_out)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
`ifdef AXIL_WSTRB_EN
    for (int k = 0; k < 4; k++)
      if (s[k]) r[8*k +: 8] = d[8*k +: 8];
`else
    if (s !== 4'bxxxx) r = d;
`endif
    return r;
  endfunction

  task automatic check_regs(input string tag);
    for (int i = 0; i < NUM_REGS; i++)
      check(tag, reg_out[i*DATA_W +: DATA_W], model[i]);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d,
                    input logic [3:0] s, input int aw_dly,
                    input int w_dly, input int b_dly);
    bit aw_done, w_done, fa, fw;
    int cyc, n, idx;
    logic [1:0] er;
    idx = int'(a >> 2);
    er = (idx < NUM_REGS) ? 2'b00 : 2'b10;
    aw_done = 0;
    w_done = 0;
    cyc = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      check("no_early_b", BVALID, 0);
      if (w_done) check("w_stall", WREADY, 0);
      if (aw_done) check("aw_stall", AWREADY, 0);
      AWADDR = a;
      WDATA = d;
      WSTRB = s;
      AWVALID = !aw_done && cyc >= aw_dly;
      WVALID = !w_done && cyc >= w_dly;
      fa = AWVALID && AWREADY;
      fw = WVALID && WREADY;
      tick;
      if (fa) aw_done = 1;
      if (fw) w_done = 1;
      cyc++;
    end
    AWVALID = 0;
    WVALID = 0;
    check("aw_w_accept", {aw_done, w_done}, 2'b11);
    n = 0;
    while (!BVALID && n < 20) begin
      tick;
      n++;
    end
    check("b_latency", n, 1);
    if (idx < NUM_REGS) model[idx] = merge(model[idx], d, s);
    check_regs("reg_after_wr");
    check("rdy_back", {AWREADY, WREADY}, 2'b11);
    repeat (b_dly) begin
      check("b_hold", {BVALID, BRESP}, {1'b1, er});
      tick;
    end
    check("b_resp", BRESP, er);
    BREADY = 1;
    tick;
    BREADY = 0;
    check("b_done", BVALID, 0);
  endtask

  task automatic rd(input logic [11:0] a, input int r_dly);
    logic [31:0] ed;
    logic [1:0] er;
    int n, idx;
    idx = int'(a >> 2);
    ARADDR = a;
    ARVALID = 1;
    n = 0;
    while (!ARREADY && n < 20) begin
      tick;
      n++;
    end
    check("ar_ready", ARREADY, 1);
    ed = (idx < NUM_REGS) ? model[idx] : 32'h0;
    er = (idx < NUM_REGS) ? 2'b00 : 2'b10;
    tick;
    ARVALID = 0;
    check("r_valid", RVALID, 1);
    check("ar_busy", ARREADY, 0);
    repeat (r_dly) begin
      check("r_hold", {RVALID, RDATA}, {1'b1, ed});
      tick;
    end
    check("r_data", RDATA, ed);
    check("r_resp", RRESP, er);
    RREADY = 1;
    tick;
    RREADY = 0;
    check("r_done", RVALID, 0);
  endtask

  initial begin
    logic [31:0] old;
    int widx, ridx;
    logic [11:0] wa, ra;
    ARESETN = 1;
    AWADDR = 0; AWVALID = 0; WDATA = 0; WSTRB = 0; WVALID = 0;
    BREADY = 0; ARADDR = 0; ARVALID = 0; RREADY = 0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = RST_VAL;
    #2 ARESETN = 0;
    tick;
    tick;
    check("rst_outs",
          {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP}, 0);
    check("rst_rdata", RDATA, 0);
    check_regs("rst_regs");
    ARESETN = 1;
    #1 check("rdy_pre_edge", {AWREADY, WREADY, ARREADY}, 3'b000);
    @(negedge ACLK);
    check("rdy_post_edge", {AWREADY, WREADY, ARREADY}, 3'b111);

    wr(12'h004, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    check("t1_reg1", reg_out[1*32 +: 32], 32'hDEADBEEF);
    wr(12'h008, 32'h11223344, 4'hF, 3, 0, 0);
    check("t2_reg2", reg_out[2*32 +: 32], 32'h11223344);

    AWADDR = 12'h00C; WDATA = 32'hCAFE0001; WSTRB = 4'hF;
    AWVALID = 1; WVALID = 1;
    tick;
    AWVALID = 0; WVALID = 0;
    tick;
    check("t3_b1", {BVALID, BRESP}, 3'b100);
    model[3] = 32'hCAFE0001;
    AWADDR = 12'h010; WDATA = 32'hCAFE0002;
    AWVALID = 1; WVALID = 1;
    tick;
    AWVALID = 0; WVALID = 0;
    for (int i = 0; i < 4; i++) begin
      check("t3_hold", {BVALID, BRESP}, 3'b100);
      check("t3_stall", {AWREADY, WREADY}, 2'b00);
      check("t3_reg4", reg_out[4*32 +: 32], model[4]);
      tick;
    end
    BREADY = 1;
    tick;
    check("t3_b2", {BVALID, BRESP}, 3'b100);
    model[4] = 32'hCAFE0002;
    check_regs("t3_regs");
    tick;
    BREADY = 0;
    check("t3_bdone", BVALID, 0);

    wr(12'h040, 32'h55555555, 4'hF, 1, 0, 2);
    rd(12'h040, 1);
    rd(12'h004, 0);
    check("t4_rdata", RDATA, 32'hDEADBEEF);

    wr(12'h000, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    wr(12'h002, 32'h11223344, 4'h5, 0, 1, 0);
`ifdef AXIL_WSTRB_EN
    check("t5_reg0", reg_out[31:0], 32'hAA22CC44);
`else
    check("t5_reg0", reg_out[31:0], 32'h11223344);
`endif
    wr(12'h000, 32'hFFFFFFFF, 4'h0, 0, 0, 0);

    old = model[2];
    AWADDR = 12'h008; WDATA = 32'h0BADF00D; WSTRB = 4'hF;
    AWVALID = 1; WVALID = 1;
    tick;
    AWVALID = 0; WVALID = 0;
    ARADDR = 12'h008; ARVALID = 1;
    tick;
    ARVALID = 0;
    check("col_valid", {RVALID, BVALID}, 2'b11);
    check("col_rdata", RDATA, old);
    model[2] = merge(old, 32'h0BADF00D, 4'hF);
    check_regs("col_regs");
    RREADY = 1; BREADY = 1;
    tick;
    RREADY = 0; BREADY = 0;
    check("col_done", {RVALID, BVALID}, 2'b00);

    for (int it = 0; it < 60; it++) begin
      widx = $urandom_range(0, NUM_REGS + 3);
      wa = 12'(widx * 4 + $urandom_range(0, 3));
      ridx = (widx + 1 + $urandom_range(0, NUM_REGS + 2)) % (NUM_REGS + 4);
      ra = 12'(ridx * 4 + $urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: wr(wa, $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3));
        1: rd(ra, $urandom_range(0, 3));
        default: fork
          wr(wa, $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3));
          rd(ra, $urandom_range(0, 3));
        join
      endcase
    end
    check_regs("rand_regs");

    AWADDR = 12'h040; WDATA = 32'h77777777; WSTRB = 4'hF;
    AWVALID = 1; WVALID = 1;
    tick;
    AWVALID = 0; WVALID = 0;
    tick;
    check("t6_b", {BVALID, BRESP}, 3'b110);
    WDATA = 32'h12345678; WVALID = 1;
    tick;
    WVALID = 0;
    check("t6_wfull", WREADY, 0);
    ARESETN = 0;
    #1;
    check("t6_outs",
          {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP}, 0);
    check("t6_rdata", RDATA, 0);
    for (int i = 0; i < NUM_REGS; i++) model[i] = RST_VAL;
    check_regs("t6_regs");
    tick;
    ARESETN = 1;
    @(negedge ACLK);
    check("t6_rdy", {AWREADY, WREADY, ARREADY}, 3'b111);
    repeat (3) begin
      check("t6_no_b", BVALID, 0);
      tick;
    end
    wr(12'h01C, 32'h600DCAFE, 4'hF, 0, 3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
